// File: rtl/peripheral_mult_seq.sv
// peripheral_mult_seq: memory-mapped 32x32 -> 64-bit radix-2 shift-add multiplier.
// Register map (word offsets, addr[1:0] ignored):
//   0x00 A (R/W), 0x04 B (R/W), 0x08 CTRL (W: bit0 start, bit1 signed),
//   0x0C STATUS (R: bit0 done, bit1 busy, bit2 signed mode), 0x10 P_LO, 0x14 P_HI.
// Optional macro MULT_SIGNED_EN enables two's-complement operation via CTRL bit1.
// Without it all operations are unsigned and STATUS bit2 reads 0.
module peripheral_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OFF_A      = 3'd0;
    localparam logic [2:0] OFF_B      = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_P_LO   = 3'd4;
    localparam logic [2:0] OFF_P_HI   = 3'd5;

    state_t             state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   p_lo, p_hi;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc, acc_next, result;
    logic [WIDTH:0]     sum;
    logic [5:0]         count;
    logic [WIDTH-1:0]   a_load, b_load;
    logic [31:0]        rd_data;
    logic [2:0]         word;
    logic               wr_en, rd_en, start, busy;
    logic               start_signed, signed_mode, neg_result;
    logic               unused_addr;

    assign word        = addr[4:2];
    assign unused_addr = ^addr[1:0];
    assign wr_en       = cs && wr;
    assign rd_en       = cs && rd;
    assign busy        = (state == BUSY);
    // CTRL writes during an operation never restart it.
    assign start       = wr_en && (word == OFF_CTRL) && d_in[0] && !busy;

`ifdef MULT_SIGNED_EN
    assign start_signed = d_in[1];

    // Latch the operating mode and the sign of the final product at launch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            signed_mode <= 1'b0;
            neg_result  <= 1'b0;
        end else if (start) begin
            signed_mode <= d_in[1];
            neg_result  <= d_in[1] & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
        end
    end
`else
    assign start_signed = 1'b0;
    assign signed_mode  = 1'b0;
    assign neg_result   = 1'b0;
`endif

    // Operand magnitudes at load; 0x8000_0000 maps to itself, which is its true magnitude.
    always_comb begin
        a_load = (start_signed && a_reg[WIDTH-1]) ? (~a_reg + WIDTH'(1)) : a_reg;
        b_load = (start_signed && b_reg[WIDTH-1]) ? (~b_reg + WIDTH'(1)) : b_reg;
    end

    // One shift-add step: the 33-bit sum keeps the carry that shifts into the top bit.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
        acc_next = {sum, acc[WIDTH-1:1]};
        result   = neg_result ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
    end

    // Register file writes plus the IDLE/BUSY/DONE sequencer and datapath.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; a start therefore loads A/B as they were before a same-edge write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            p_lo   <= '0;
            p_hi   <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            if (wr_en && (word == OFF_A)) a_reg <= d_in;
            if (wr_en && (word == OFF_B)) b_reg <= d_in;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= a_load;
                        mplier <= b_load;
                        acc    <= '0;
                        count  <= '0;
                        done   <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 6'd1;
                    if (count == 6'(WIDTH - 1)) begin
                        p_lo  <= result[WIDTH-1:0];
                        p_hi  <= result[2*WIDTH-1:WIDTH];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux for the addressed register; unmapped offsets return 0.
    // NOTE: rd_data gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = '0;
        case (word)
            OFF_A:      rd_data = a_reg;
            OFF_B:      rd_data = b_reg;
            OFF_STATUS: rd_data = {29'b0, signed_mode, busy, done};
            OFF_P_LO:   rd_data = p_lo;
            OFF_P_HI:   rd_data = p_hi;
            default:    rd_data = '0;
        endcase
    end

    // Registered read data, forced to 0 when not selected so the SoC mux stays clean.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            d_out <= '0;
        end else begin
            d_out <= rd_en ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_peripheral_mult_seq.sv
// Scoreboard bench for peripheral_mult_seq: a driver issues bus cycles and pushes the
// expected read data from a transaction-level model; a monitor pops and compares d_out.
module tb_peripheral_mult_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;
    logic        done;

    peripheral_mult_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (d_in),
        .cs     (cs),
        .addr   (addr),
        .rd     (rd),
        .wr     (wr),
        .d_out  (d_out),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   edge_n = 0;

    // Reference model: register contents and operation timing at the transaction level.
    logic [31:0] m_a, m_b;
    logic [63:0] m_p, m_pending;
    logic        m_done, m_busy, m_sgn;
    int          m_start;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, actual, expected, edge_n);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (sgn) return 64'(sa * sb);
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic start_sign(input logic [31:0] d);
`ifdef MULT_SIGNED_EN
        return d[1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return m_a;
            3'd1:    return m_b;
            3'd3:    return {29'b0, m_sgn, m_busy, m_done};
            3'd4:    return m_p[31:0];
            3'd5:    return m_p[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_p = '0; m_pending = '0;
        m_done = 1'b0; m_busy = 1'b0; m_sgn = 1'b0; m_start = 0;
    endtask

    // Effect of one clock edge on the model; a product becomes visible 32 edges after its start edge.
    task automatic model_edge(input logic do_wr, input logic [4:0] a, input logic [31:0] d);
        logic was_busy;
        was_busy = m_busy;
        if (do_wr && a[4:2] == 3'd2 && d[0] && !was_busy) begin
            m_sgn     = start_sign(d);
            m_pending = ref_product(m_a, m_b, m_sgn);
            m_start   = edge_n;
            m_busy    = 1'b1;
            m_done    = 1'b0;
        end
        if (was_busy && edge_n == m_start + 32) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_p    = m_pending;
        end
        if (do_wr && a[4:2] == 3'd0) m_a = d;
        if (do_wr && a[4:2] == 3'd1) m_b = d;
    endtask

    task automatic bus_cycle(input logic do_wr, input logic do_rd, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        cs   = do_wr | do_rd;
        wr   = do_wr;
        rd   = do_rd;
        addr = a;
        d_in = d;
        if (do_rd) begin
            e.name  = $sformatf("read_0x%02h", a);
            e.value = model_read(a);
            exp_q.push_back(e);
        end
        @(posedge clk);
        edge_n++;
        model_edge(do_wr, a, d);
        #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        check("done_flag", {31'b0, done}, {31'b0, m_done});
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [4:0] a);
        bus_cycle(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 5'h0, 32'h0);
    endtask

    // Start, poll STATUS until the model says done (bounded), then read the product.
    task automatic start_and_wait(input logic [31:0] ctrl);
        wr_reg(5'h08, ctrl);
        for (int i = 0; i < 40 && !m_done; i++) rd_reg(5'h0C);
        rd_reg(5'h0C);
        rd_reg(5'h10);
        rd_reg(5'h14);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl);
        wr_reg(5'h00, a);
        wr_reg(5'h04, b);
        start_and_wait(ctrl);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        edge_n++;
        model_reset();
        #1;
        check("reset_done", {31'b0, done}, {31'b0, m_done});
        check("reset_d_out", d_out, 32'h0);
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: a read strobe sampled at an edge must show its data on d_out after that edge.
    initial begin
        logic hit;
        exp_t e;
        forever begin
            @(posedge clk);
            hit = cs && rd;
            @(negedge clk);
            if (hit) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_read: got 0x%08h, required no read response", d_out);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, d_out, e.value);
                end
            end else begin
                check("d_out_idle", d_out, 32'h0);
            end
        end
    end

    initial begin
        int          kind;
        logic [4:0]  ra;
        logic [31:0] rdat;

        model_reset();
        do_reset();
        do_reset();
        rd_reg(5'h0C);
        rd_reg(5'h10);

        // Directed operations from the test plan.
        run_op(32'd3, 32'd5, 32'h1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        run_op(32'h1234_5678, 32'h0, 32'h1);
        start_and_wait(32'h1);
        run_op(32'hFFFF_FFFD, 32'd7, 32'h3);
        run_op(32'h8000_0000, 32'h8000_0000, 32'h3);

        // Writes during BUSY affect only the next operation; CTRL is ignored.
        wr_reg(5'h00, 32'd7);
        wr_reg(5'h04, 32'd9);
        wr_reg(5'h08, 32'h1);
        idle(8);
        wr_reg(5'h00, 32'd2);
        wr_reg(5'h04, 32'd2);
        wr_reg(5'h08, 32'h1);
        rd_reg(5'h10);
        rd_reg(5'h00);
        for (int i = 0; i < 40 && !m_done; i++) rd_reg(5'h0C);
        rd_reg(5'h10);
        rd_reg(5'h14);
        start_and_wait(32'h1);

        // Reset in the middle of an operation, then a normal operation.
        wr_reg(5'h00, 32'd100);
        wr_reg(5'h04, 32'd100);
        wr_reg(5'h08, 32'h1);
        idle(13);
        do_reset();
        rd_reg(5'h00);
        rd_reg(5'h04);
        rd_reg(5'h0C);
        rd_reg(5'h10);
        rd_reg(5'h14);
        run_op(32'd100, 32'd100, 32'h1);

        // Unmapped offsets and unaligned addresses.
        rd_reg(5'h08);
        rd_reg(5'h18);
        rd_reg(5'h1C);
        rd_reg(5'h13);

        // Random bus traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            kind = $urandom_range(0, 11);
            ra   = 5'($urandom_range(0, 31));
            rdat = rand_word();
            case (kind)
                0, 1:    idle(1);
                2, 3, 4: rd_reg(ra);
                5:       rd_reg(5'h0C);
                6:       wr_reg(5'h00, rdat);
                7:       wr_reg(5'h04, rdat);
                8, 9:    wr_reg(5'h08, {30'b0, 1'($urandom_range(0, 1)), 1'b1});
                10:      wr_reg(ra, rdat);
                default: begin
                    rd_reg(5'h10);
                    rd_reg(5'h14);
                end
            endcase
        end

        idle(3);
        check("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
